// File: rtl/arb_req_ctrl.sv
// Requester-side companion to a round-robin arbiter: per-client pending counters drive req,
// registered grants retire one pending request each and are presented downstream via valid/ready.
module arb_req_ctrl #(
  parameter int N     = 8,
  parameter int LN    = $clog2(N),
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en_i,
  input  logic [N-1:0]     push_i,
  output logic [N-1:0]     full_o,
  output logic [N-1:0]     ovf_o,
  output logic [N-1:0]     req_o,
  input  logic [LN-1:0]    grant_i,
  input  logic             grant_valid_i,
  output logic             out_valid_o,
  output logic [LN-1:0]    out_id_o,
  input  logic             out_ready_i,
  output logic [CW+LN-1:0] pend_total_o
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [N-1:0][CW-1:0]    pending_q, pending_d;
  logic [N-1:0]            ovf_q, ovf_d;
  logic [LN-1:0]           out_id_q, out_id_d;
  logic [CW+LN-1:0]        pend_total_q, pend_total_d;

  logic [N-1:0]            hit;
  logic [N-1:0]            retire;
  logic                    slot_free;
  logic                    accept;

  // A grant only counts if it names an in-range client that still has work; stale or
  // out-of-range grants simply match no client.
  for (genvar gi = 0; gi < N; gi++) begin : g_hit
    assign hit[gi] = (grant_i == LN'(gi)) && (pending_q[gi] != '0);
  end

  assign slot_free = (state_q == IDLE) || out_ready_i;
  assign accept    = clk_en_i && grant_valid_i && slot_free && (|hit);
  assign retire    = accept ? hit : '0;

  for (genvar gi = 0; gi < N; gi++) begin : g_client
    logic [CW-1:0] cnt_d;
    logic          ovf_set;

    // Retire-before-add: a push coinciding with a retire never overflows.
    always_comb begin
      cnt_d   = pending_q[gi];
      ovf_set = 1'b0;
      if (retire[gi] && !push_i[gi]) begin
        cnt_d = pending_q[gi] - CW'(1);
      end else if (!retire[gi] && push_i[gi]) begin
        if (pending_q[gi] == CW'(DEPTH)) begin
          ovf_set = 1'b1;
        end else begin
          cnt_d = pending_q[gi] + CW'(1);
        end
      end
    end

    assign pending_d[gi] = cnt_d;
    assign ovf_d[gi]     = ovf_q[gi] | ovf_set;
    assign full_o[gi]    = (pending_q[gi] == CW'(DEPTH));
    assign req_o[gi]     = (pending_q[gi] != '0);
  end

  always_comb begin
    pend_total_d = '0;
    for (int i = 0; i < N; i++) begin
      pend_total_d = pend_total_d + (CW+LN)'(pending_d[i]);
    end
  end

  always_comb begin
    state_d  = state_q;
    out_id_d = out_id_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          state_d = accept ? HOLD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      out_id_d = grant_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      ovf_q        <= '0;
      out_id_q     <= '0;
      pend_total_q <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      ovf_q        <= ovf_d;
      out_id_q     <= out_id_d;
      pend_total_q <= pend_total_d;
    end
  end

  assign ovf_o        = ovf_q;
  assign out_valid_o  = (state_q == HOLD);
  assign out_id_o     = out_id_q;
  assign pend_total_o = pend_total_q;

endmodule

// File: tb/tb_arb_req_ctrl.sv
// Closed-loop bench: a round-robin arbiter model feeds grants back, a scoreboard queue holds
// the expected served client order and is checked on every downstream handshake.
module tb_arb_req_ctrl;
  localparam int N     = 8;
  localparam int LN    = 3;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int PW    = CW + LN;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_en;
  logic [N-1:0]  push;
  logic [N-1:0]  full;
  logic [N-1:0]  ovf;
  logic [N-1:0]  req;
  logic [LN-1:0] grant;
  logic          grant_valid;
  logic          out_valid;
  logic [LN-1:0] out_id;
  logic          out_ready;
  logic [PW-1:0] pend_total;

  logic [LN-1:0] arb_grant, arb_ptr, man_grant;
  logic          arb_valid, man_valid, manual;
  logic [LN:0]   pick_w;

  int n_cmp = 0;
  int n_err = 0;
  int valid_cycles = 0;
  int sb_q[$];

  always #5 clk = ~clk;

  arb_req_ctrl #(.N(N), .LN(LN), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clk_en_i      (clk_en),
    .push_i        (push),
    .full_o        (full),
    .ovf_o         (ovf),
    .req_o         (req),
    .grant_i       (grant),
    .grant_valid_i (grant_valid),
    .out_valid_o   (out_valid),
    .out_id_o      (out_id),
    .out_ready_i   (out_ready),
    .pend_total_o  (pend_total)
  );

  function automatic logic [LN:0] rr_pick(input logic [N-1:0] r, input logic [LN-1:0] last);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (r[idx]) return {1'b1, LN'(idx)};
    end
    return '0;
  endfunction

  // Registered round-robin arbiter model sharing clk_en with the DUT.
  assign pick_w = rr_pick(req, arb_ptr);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_ptr   <= LN'(N - 1);
      arb_grant <= '0;
      arb_valid <= 1'b0;
    end else if (clk_en) begin
      arb_valid <= pick_w[LN];
      if (pick_w[LN]) begin
        arb_grant <= pick_w[LN-1:0];
        arb_ptr   <= pick_w[LN-1:0];
      end
    end
  end

  assign grant       = manual ? man_grant : arb_grant;
  assign grant_valid = manual ? man_valid : arb_valid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          int e;
          e = sb_q.pop_front();
          $display("txn t=%0t out_id=%0d expected=%0d", $time, out_id, e);
          chk("out_id", 32'(out_id), 32'(e));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    push      = '0;
    manual    = 1'b0;
    man_valid = 1'b0;
    man_grant = '0;
    clk_en    = 1'b1;
    out_ready = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int i = 0;
    while (!out_valid && i < budget) begin
      step(1);
      i++;
    end
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int i = 0;
    while (!(req == '0 && !out_valid && sb_q.size() == 0) && i < budget) begin
      step(1);
      i++;
    end
    chk(tag, 32'(req == '0 && !out_valid && sb_q.size() == 0), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    push = '0; clk_en = 1'b1; out_ready = 1'b1;
    manual = 1'b0; man_valid = 1'b0; man_grant = '0;
    step(2);
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_id", 32'(out_id), 32'h0);
    chk("rst_total", 32'(pend_total), 32'h0);
    rst_n = 1'b1;
    step(1);

    // Single request through the loop
    valid_cycles = 0;
    sb_q.push_back(3);
    push = 8'h08;
    step(1);
    push = '0;
    chk("t1_req", 32'(req), 32'h08);
    chk("t1_total", 32'(pend_total), 32'd1);
    wait_drain("t1_drain", 20);
    chk("t1_pulses", 32'(valid_cycles), 32'd1);
    chk("t1_total_end", 32'(pend_total), 32'd0);

    // Fairness burst
    do_reset();
    valid_cycles = 0;
    foreach (sb_q[i]) sb_q.delete(i);
    sb_q.push_back(0); sb_q.push_back(2); sb_q.push_back(5);
    sb_q.push_back(0); sb_q.push_back(2); sb_q.push_back(5);
    push = 8'h25;
    step(2);
    push = '0;
    chk("t2_total", 32'(pend_total), 32'd6);
    wait_drain("t2_drain", 40);
    chk("t2_total_end", 32'(pend_total), 32'd0);
    chk("t2_cycles", 32'(valid_cycles), 32'd6);

    // Backpressure then back-to-back
    do_reset();
    out_ready = 1'b0;
    sb_q.push_back(1); sb_q.push_back(1);
    push = 8'h02;
    step(2);
    push = '0;
    wait_valid("t3_wait", 20);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_id", 32'(out_id), 32'd1);
      chk("t3_hold_total", 32'(pend_total), 32'd1);
      step(1);
    end
    out_ready = 1'b1;
    step(1);
    chk("t3_b2b_valid", 32'(out_valid), 32'd1);
    chk("t3_b2b_id", 32'(out_id), 32'd1);
    chk("t3_b2b_total", 32'(pend_total), 32'd0);
    wait_drain("t3_drain", 20);

    // Overflow with clk_en low
    do_reset();
    clk_en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      push = 8'h40;
      step(1);
      chk("t4_total", 32'(pend_total), 32'((k < DEPTH) ? k : DEPTH));
      chk("t4_full", 32'(full), (k >= DEPTH) ? 32'h40 : 32'h0);
      chk("t4_ovf", 32'(ovf), (k > DEPTH) ? 32'h40 : 32'h0);
    end
    push = '0;
    chk("t4_en_low_req", 32'(req), 32'h40);
    manual = 1'b1; man_grant = 3'd6; man_valid = 1'b1; clk_en = 1'b1;
    sb_q.push_back(6);
    push = 8'h40;
    step(1);
    push = '0; man_valid = 1'b0; clk_en = 1'b0;
    chk("t4_same_total", 32'(pend_total), 32'd4);
    chk("t4_same_full", 32'(full), 32'h40);
    chk("t4_same_ovf", 32'(ovf), 32'h40);
    chk("t4_same_valid", 32'(out_valid), 32'd1);
    step(1);
    chk("t4_en_low_release", 32'(out_valid), 32'd0);

    // Stale grant to a drained client
    man_grant = 3'd4; man_valid = 1'b1; clk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t5_valid", 32'(out_valid), 32'd0);
      chk("t5_total", 32'(pend_total), 32'd4);
    end
    man_valid = 1'b0;
    manual = 1'b0;

    // Asynchronous reset mid-HOLD
    out_ready = 1'b0;
    wait_valid("t6_wait", 20);
    chk("t6_pre_total", 32'(pend_total), 32'd3);
    chk("t6_pre_ovf", 32'(ovf), 32'h40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_req", 32'(req), 32'h0);
    chk("t6_full", 32'(full), 32'h0);
    chk("t6_total", 32'(pend_total), 32'd0);
    chk("t6_ovf", 32'(ovf), 32'h0);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/arb_req_ctrl.md
Name: arb_req_ctrl

Overview:
Requester-side companion to the round-robin arbiter. It holds per-client pending-request counts and drives the arbiter's `req` vector. It consumes the arbiter's registered `grant`/`valid`, retires one pending request of the granted client, and presents the winner downstream through a valid/ready handshake. It sits between the client pulse sources and the arbiter, closing the request/grant loop.

Parameters:
- N, 8, number of clients; equals the arbiter's N.
- LN, $clog2(N), width of grant and client index.
- DEPTH, 4, maximum outstanding requests per client.
- CW, $clog2(DEPTH+1), width of each pending counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low.
- clk_en  input  1  enable shared with the arbiter; gates grant consumption only.
- push  input  N  per-client request pulse; each high cycle adds one pending request.
- full  output  N  client i has pending == DEPTH.
- ovf  output  N  sticky; client i pushed while full.
- req  output  N  to arbiter; req[i] = (pending[i] != 0).
- grant  input  LN  arbiter grant index.
- grant_valid  input  1  arbiter valid.
- out_valid  output  1  served transaction available downstream.
- out_id  output  LN  client index of the served transaction.
- out_ready  input  1  downstream accept.
- pend_total  output  CW+LN  sum of all pending counts, registered.

Behaviour:
- Reset (rst low, asynchronous):
  - pending[*] = 0, ovf = 0, out_valid = 0, out_id = 0, pend_total = 0.
  - Consequently req = 0 and full = 0.
- Output FSM, two states:
  - IDLE: out_valid = 0.
  - HOLD: out_valid = 1.
  - IDLE→HOLD on accept.
  - HOLD→IDLE on out_ready with no same-cycle accept.
  - HOLD→HOLD on out_ready with a same-cycle accept; out_id takes the new index.
  - While in HOLD, out_id stays stable until out_ready.
- Accept condition:
  - accept = clk_en & grant_valid & (grant < N) & (pending[grant] != 0) & (state == IDLE | out_ready).
  - On accept:
    - pending[grant] decrements.
    - out_id <= grant on the next edge.
    - out_valid = 1 from the cycle after accept (1-cycle latency).
- Stale grant: the arbiter's grant is registered and may name a client already drained. If pending[grant] == 0, the grant is ignored; no state change and no error.
- Out-of-range grant (N not a power of 2, grant >= N): ignored.
- Backpressure: in HOLD with out_ready low, no accept occurs. Pending counts and req stay asserted, so the arbiter keeps rotating. No grant is lost, because the pending count is not decremented.
- Push handling (independent of clk_en):
  - pending[i] < DEPTH: increment.
  - pending[i] == DEPTH: push is dropped and ovf[i] is set; ovf clears only on reset.
- Simultaneous push and accept on the same client:
  - Net count is unchanged.
  - If the count was DEPTH, the push is NOT dropped and ovf is not set (retire-before-add).
- pend_total: registered; updates the cycle after each change, tracking the sum of the next-state counters.
- clk_en low:
  - No accept.
  - The downstream handshake still completes (HOLD→IDLE on out_ready).
  - Pushes still count.
- Reset mid-transaction: out_valid drops immediately (async) and all pending requests are discarded.

Test Plan:
1. Single push, push[3] pulse, clk_en = 1, arbiter tied in loop, out_ready = 1:
   - req = 8'h08 the cycle after the push.
   - Once grant = 3 and valid: out_valid pulses one cycle with out_id = 3; req returns to 0; pend_total goes 1→0.
2. Fairness, push[0], push[2] and push[5] twice each in one burst:
   - Serve order out_id = 0, 2, 5, 0, 2, 5.
   - pend_total goes 6→0.
   - No client is served twice consecutively.
3. Backpressure, pending[1] = 2, out_ready = 0 for 5 cycles:
   - out_valid = 1 and out_id = 1 held all 5 cycles.
   - pending[1] stays 1.
   - On out_ready = 1, the next grant is served back-to-back (out_valid stays high, out_id = 1), then pending[1] = 0.
4. Overflow, 5 pushes to client 6 with clk_en = 0:
   - full[6] = 1 after the 4th push; ovf[6] = 1 after the 5th; pending[6] = 4.
   - Then push[6] and an accept of client 6 in the same cycle: pending[6] stays 4 and ovf is unchanged.
5. Stale grant, grant = 4 and grant_valid = 1 with pending[4] = 0 (another client pending):
   - No out_valid and no counter change.
6. Async reset, rst low mid-HOLD with pending nonzero:
   - out_valid, req, full and pend_total go to 0 without a clock edge.
   - ovf is cleared.
